// File: rtl/dlx_bus_pkg.sv
// Shared DLX data-bus definitions: decoder state encoding, default widths
// and the LED/RAM system map.
package dlx_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        RESP
    } mmio_state_t;

    localparam int unsigned DLX_ADDR_W = 32;

    localparam logic [31:0] LED_BASE = 32'h0000_0001;
    localparam logic [31:0] LED_MASK = 32'hFFFF_FFFF;
    localparam logic [31:0] RAM_BASE = 32'h0000_0000;
    localparam logic [31:0] RAM_MASK = 32'h0000_0000;

    // Width of an index into n items, never narrower than one bit.
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mmio_addr_match.sv
// Combinational window match: compares an address against every slave
// base/mask pair and priority-encodes the lowest matching slave.
module mmio_addr_match
    import dlx_bus_pkg::*;
#(
    parameter int unsigned                       ADDR_W   = DLX_ADDR_W,
    parameter int unsigned                       N_SLAVES = 4,
    parameter logic [N_SLAVES-1:0][ADDR_W-1:0]   SLV_BASE = '0,
    parameter logic [N_SLAVES-1:0][ADDR_W-1:0]   SLV_MASK = '0
) (
    input  logic [ADDR_W-1:0]                    addr,
    output logic                                 hit_any,
    output logic [idx_width(N_SLAVES)-1:0]       sel
);

    localparam int unsigned SEL_W = idx_width(N_SLAVES);

    // NOTE: every output gets a default before the loop, so no latch is inferred.
    always_comb begin
        hit_any = 1'b0;
        sel     = '0;
        // Scan downwards so the lowest matching index is the last one written.
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i]) == (SLV_BASE[i] & SLV_MASK[i])) begin
                hit_any = 1'b1;
                sel     = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mmio_decoder.sv
// Registered chip-select decoder for the DLX MEM-stage data bus: one request
// at a time, one-hot select, ack wait with optional timeout, one-cycle response.
module mmio_decoder
    import dlx_bus_pkg::*;
#(
    parameter int unsigned                       ADDR_W   = DLX_ADDR_W,
    parameter int unsigned                       N_SLAVES = 4,
    parameter logic [N_SLAVES-1:0][ADDR_W-1:0]   SLV_BASE = '0,
    parameter logic [N_SLAVES-1:0][ADDR_W-1:0]   SLV_MASK = '0,
    parameter int unsigned                       TIMEOUT  = 15
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [ADDR_W-1:0]                    req_addr,
    input  logic                                 req_we,
    output logic [N_SLAVES-1:0]                  cs,
    output logic                                 cs_we,
    input  logic [N_SLAVES-1:0]                  slv_ack,
    output logic                                 rsp_valid,
    output logic                                 rsp_err,
    output logic [idx_width(N_SLAVES)-1:0]       rsp_slave
);

    localparam int unsigned SEL_W   = idx_width(N_SLAVES);
    localparam int unsigned CNT_W   = idx_width(TIMEOUT);
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    mmio_state_t         state_q, state_d;
    logic [N_SLAVES-1:0] cs_q, cs_d;
    logic                cs_we_q, cs_we_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [SEL_W-1:0]    rsp_slave_q, rsp_slave_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                match_hit;
    logic [SEL_W-1:0]    match_sel;
    logic                accept;
    logic                mapped;
    logic                ack_hit;
    logic                timeout_hit;

    mmio_addr_match #(
        .ADDR_W   (ADDR_W),
        .N_SLAVES (N_SLAVES),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_match (
        .addr     (req_addr),
        .hit_any  (match_hit),
        .sel      (match_sel)
    );

    assign req_ready   = (state_q == IDLE);
    assign accept      = req_valid && req_ready;
    // Address zero is a null pointer dereference, never a real access.
    assign mapped      = match_hit && (req_addr != '0);
    assign ack_hit     = slv_ack[sel_q];
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST));

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cs_q        <= '0;
            cs_we_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_slave_q <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cs_q        <= cs_d;
            cs_we_q     <= cs_we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_slave_q <= rsp_slave_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = mapped ? ACTIVE : RESP;
            ACTIVE:  if (ack_hit || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cs_d        = cs_q;
        cs_we_d     = cs_we_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_slave_d = '0;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept && mapped) begin
                    cs_d    = N_SLAVES'(1) << match_sel;
                    cs_we_d = req_we;
                    sel_d   = match_sel;
                    cnt_d   = '0;
                end else if (accept) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            ACTIVE: begin
                cnt_d = cnt_q + 1'b1;
                // Ack is checked first so it wins over a same-cycle timeout.
                if (ack_hit) begin
                    cs_d        = '0;
                    cs_we_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_slave_d = sel_q;
                end else if (timeout_hit) begin
                    cs_d        = '0;
                    cs_we_d     = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign cs        = cs_q;
    assign cs_we     = cs_we_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_slave = rsp_slave_q;

endmodule

// File: tb/tb_mmio_decoder.sv
// Directed bench: LED/RAM map with a short timeout, plus a 4-slave map with
// overlapping windows and an unmapped hole.
module tb_mmio_decoder;
    import dlx_bus_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic        a_req_valid, a_req_ready, a_req_we, a_cs_we;
    logic [31:0] a_req_addr;
    logic [1:0]  a_cs, a_slv_ack;
    logic        a_rsp_valid, a_rsp_err;
    logic [0:0]  a_rsp_slave;

    logic        b_req_valid, b_req_ready, b_req_we, b_cs_we;
    logic [31:0] b_req_addr;
    logic [3:0]  b_cs, b_slv_ack;
    logic        b_rsp_valid, b_rsp_err;
    logic [1:0]  b_rsp_slave;

    mmio_decoder #(
        .ADDR_W   (32),
        .N_SLAVES (2),
        .SLV_BASE ({RAM_BASE, LED_BASE}),
        .SLV_MASK ({RAM_MASK, LED_MASK}),
        .TIMEOUT  (4)
    ) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (a_req_valid),
        .req_ready (a_req_ready),
        .req_addr  (a_req_addr),
        .req_we    (a_req_we),
        .cs        (a_cs),
        .cs_we     (a_cs_we),
        .slv_ack   (a_slv_ack),
        .rsp_valid (a_rsp_valid),
        .rsp_err   (a_rsp_err),
        .rsp_slave (a_rsp_slave)
    );

    mmio_decoder #(
        .ADDR_W   (32),
        .N_SLAVES (4),
        .SLV_BASE ({32'h2000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000}),
        .SLV_MASK ({32'hFF00_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000}),
        .TIMEOUT  (15)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (b_req_valid),
        .req_ready (b_req_ready),
        .req_addr  (b_req_addr),
        .req_we    (b_req_we),
        .cs        (b_cs),
        .cs_we     (b_cs_we),
        .slv_ack   (b_slv_ack),
        .rsp_valid (b_rsp_valid),
        .rsp_err   (b_rsp_err),
        .rsp_slave (b_rsp_slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        a_req_valid = 1'b1;
        a_req_addr  = 32'h1;
        a_req_we    = 1'b1;
        a_slv_ack   = '0;
        b_req_valid = 1'b1;
        b_req_addr  = 32'h1000_0000;
        b_req_we    = 1'b0;
        b_slv_ack   = '0;

        // Reset held 3 cycles with requests pending: nothing may be accepted.
        repeat (3) tick();
        check("rst_a_cs", 32'(a_cs), 32'h0);
        check("rst_a_rsp_valid", 32'(a_rsp_valid), 32'h0);
        check("rst_b_cs", 32'(b_cs), 32'h0);
        rst_n       = 1'b1;
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        tick();
        check("rel_a_ready", 32'(a_req_ready), 32'h1);
        check("rel_a_cs", 32'(a_cs), 32'h0);
        check("rel_a_rsp_valid", 32'(a_rsp_valid), 32'h0);
        check("rel_b_ready", 32'(b_req_ready), 32'h1);

        // LED store, ack at cycle 2, response at cycle 3.
        a_req_valid = 1'b1; a_req_addr = 32'h1; a_req_we = 1'b1;
        tick();
        check("led_c1_cs", 32'(a_cs), 32'h1);
        check("led_c1_we", 32'(a_cs_we), 32'h1);
        check("led_c1_ready", 32'(a_req_ready), 32'h0);
        a_req_valid = 1'b0; a_req_addr = 32'h40; a_req_we = 1'b0;
        tick();
        check("led_c2_cs", 32'(a_cs), 32'h1);
        check("led_c2_we", 32'(a_cs_we), 32'h1);
        check("led_c2_rsp", 32'(a_rsp_valid), 32'h0);
        a_slv_ack = 2'b01;
        tick();
        a_slv_ack = 2'b00;
        check("led_c3_rsp", 32'(a_rsp_valid), 32'h1);
        check("led_c3_err", 32'(a_rsp_err), 32'h0);
        check("led_c3_slave", 32'(a_rsp_slave), 32'h0);
        check("led_c3_cs", 32'(a_cs), 32'h0);
        tick();
        check("led_c4_rsp", 32'(a_rsp_valid), 32'h0);
        check("led_c4_ready", 32'(a_req_ready), 32'h1);

        // RAM load, ack at cycle 1, response at cycle 2.
        a_req_valid = 1'b1; a_req_addr = 32'h40; a_req_we = 1'b0;
        tick();
        check("ram_c1_cs", 32'(a_cs), 32'h2);
        check("ram_c1_we", 32'(a_cs_we), 32'h0);
        a_req_valid = 1'b0; a_slv_ack = 2'b10;
        tick();
        a_slv_ack = 2'b00;
        check("ram_c2_rsp", 32'(a_rsp_valid), 32'h1);
        check("ram_c2_err", 32'(a_rsp_err), 32'h0);
        check("ram_c2_slave", 32'(a_rsp_slave), 32'h1);
        tick();

        // RAM access with a spurious LED ack first.
        a_req_valid = 1'b1; a_req_addr = 32'h40;
        tick();
        a_req_valid = 1'b0; a_slv_ack = 2'b01;
        tick();
        check("spur_c2_cs", 32'(a_cs), 32'h2);
        check("spur_c2_rsp", 32'(a_rsp_valid), 32'h0);
        a_slv_ack = 2'b10;
        tick();
        a_slv_ack = 2'b00;
        check("spur_c3_rsp", 32'(a_rsp_valid), 32'h1);
        check("spur_c3_slave", 32'(a_rsp_slave), 32'h1);
        tick();

        // Null address: immediate error, cs never driven.
        a_req_valid = 1'b1; a_req_addr = 32'h0;
        tick();
        a_req_valid = 1'b0;
        check("null_c1_rsp", 32'(a_rsp_valid), 32'h1);
        check("null_c1_err", 32'(a_rsp_err), 32'h1);
        check("null_c1_slave", 32'(a_rsp_slave), 32'h0);
        check("null_c1_cs", 32'(a_cs), 32'h0);
        tick();
        check("null_c2_rsp", 32'(a_rsp_valid), 32'h0);
        check("null_c2_ready", 32'(a_req_ready), 32'h1);

        // Unmapped hole in the 4-slave map.
        b_req_valid = 1'b1; b_req_addr = 32'hFFFF_0000;
        tick();
        b_req_valid = 1'b0;
        check("unmap_c1_rsp", 32'(b_rsp_valid), 32'h1);
        check("unmap_c1_err", 32'(b_rsp_err), 32'h1);
        check("unmap_c1_cs", 32'(b_cs), 32'h0);
        tick();

        // Overlap of slaves 1 and 3: lowest index wins.
        b_req_valid = 1'b1; b_req_addr = 32'h2000_0010; b_req_we = 1'b1;
        tick();
        check("ovl_c1_cs", 32'(b_cs), 32'h2);
        check("ovl_c1_we", 32'(b_cs_we), 32'h1);
        b_req_valid = 1'b0; b_slv_ack = 4'b0010;
        tick();
        b_slv_ack = 4'b0000;
        check("ovl_c2_rsp", 32'(b_rsp_valid), 32'h1);
        check("ovl_c2_slave", 32'(b_rsp_slave), 32'h1);
        tick();

        b_req_valid = 1'b1; b_req_addr = 32'h3000_0000; b_req_we = 1'b0;
        tick();
        check("s2_c1_cs", 32'(b_cs), 32'h4);
        b_req_valid = 1'b0; b_slv_ack = 4'b0100;
        tick();
        b_slv_ack = 4'b0000;
        check("s2_c2_err", 32'(b_rsp_err), 32'h0);
        check("s2_c2_slave", 32'(b_rsp_slave), 32'h2);
        tick();

        // Timeout of 4: cs high cycles 1-4, error at cycle 5.
        a_req_valid = 1'b1; a_req_addr = 32'h40;
        tick();
        a_req_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("to_c%0d_cs", c), 32'(a_cs), 32'h2);
            check($sformatf("to_c%0d_rsp", c), 32'(a_rsp_valid), 32'h0);
            tick();
        end
        check("to_c5_rsp", 32'(a_rsp_valid), 32'h1);
        check("to_c5_err", 32'(a_rsp_err), 32'h1);
        check("to_c5_slave", 32'(a_rsp_slave), 32'h0);
        check("to_c5_cs", 32'(a_cs), 32'h0);
        tick();

        // Ack in the last allowed cycle wins over the timeout.
        a_req_valid = 1'b1; a_req_addr = 32'h40;
        tick();
        a_req_valid = 1'b0;
        repeat (3) tick();
        check("tw_c4_cs", 32'(a_cs), 32'h2);
        a_slv_ack = 2'b10;
        tick();
        a_slv_ack = 2'b00;
        check("tw_c5_rsp", 32'(a_rsp_valid), 32'h1);
        check("tw_c5_err", 32'(a_rsp_err), 32'h0);
        check("tw_c5_slave", 32'(a_rsp_slave), 32'h1);
        tick();

        // Reset during ACTIVE aborts silently; a new request follows.
        a_req_valid = 1'b1; a_req_addr = 32'h40;
        tick();
        a_req_valid = 1'b0;
        tick();
        check("mid_c2_cs", 32'(a_cs), 32'h2);
        rst_n = 1'b0;
        tick();
        check("mid_c3_cs", 32'(a_cs), 32'h0);
        check("mid_c3_rsp", 32'(a_rsp_valid), 32'h0);
        rst_n = 1'b1;
        tick();
        check("mid_c4_rsp", 32'(a_rsp_valid), 32'h0);
        check("mid_c4_ready", 32'(a_req_ready), 32'h1);
        a_req_valid = 1'b1; a_req_addr = 32'h1;
        tick();
        a_req_valid = 1'b0;
        check("mid_c5_cs", 32'(a_cs), 32'h1);
        a_slv_ack = 2'b01;
        tick();
        a_slv_ack = 2'b00;
        check("mid_c6_rsp", 32'(a_rsp_valid), 32'h1);
        check("mid_c6_slave", 32'(a_rsp_slave), 32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
